// File: rtl/mem_port_arbiter_if.sv
// Requester (P and D) and memory-side signals of the shared memory port.
// Latency: none, wires only; read data returns one cycle after a grant.
// Backpressure: a requester holds req/we/addr/wdata until it sees gnt at a rising edge.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 16
);
  // processor port
  logic              p_req;
  logic              p_we;
  logic [ADDR_W-1:0] p_addr;
  logic [DATA_W-1:0] p_wdata;
  logic              p_gnt;
  logic              p_rvalid;
  logic [DATA_W-1:0] p_rdata;
  // debug / loader port
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  // memory pins
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_wren;
  logic [DATA_W-1:0] mem_q;
  // starvation visibility
  logic [3:0]        d_wait;

  // arbiter view
  modport slave (
    input  p_req, p_we, p_addr, p_wdata,
    input  d_req, d_we, d_addr, d_wdata,
    input  mem_q,
    output p_gnt, p_rvalid, p_rdata,
    output d_gnt, d_rvalid, d_rdata,
    output mem_addr, mem_wdata, mem_wren,
    output d_wait
  );

  // requester and memory view
  modport master (
    output p_req, p_we, p_addr, p_wdata,
    output d_req, d_we, d_addr, d_wdata,
    output mem_q,
    input  p_gnt, p_rvalid, p_rdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_addr, mem_wdata, mem_wren,
    input  d_wait
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between processor (P) and debug/loader (D); P priority with D starvation guard.
// Latency: grant and memory drive combinational in the request cycle; read data/rvalid one cycle after grant.
// Backpressure: loser sees gnt=0 and holds its request; ARB_ROUND_ROBIN_EN selects alternating arbitration.
module mem_port_arbiter #(
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 16,
  parameter int MAX_WAIT = 4
) (
  input  logic               clock,
  input  logic               resetn,
  mem_port_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, OWN_P, OWN_D} state_t;

  localparam logic [3:0] MAX_WAIT_L = 4'(MAX_WAIT);

  state_t            state;
  state_t            state_nx;
  logic              p_gnt;
  logic              d_gnt;
  logic              d_wins;
  logic [3:0]        wait_q;
  logic              p_pend;
  logic              d_pend;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] p_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic [ADDR_W-1:0] addr_c;
  logic [DATA_W-1:0] wdata_c;
  logic              wren_c;

  // state register: remembers who owned the memory last cycle
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nx;
  end

  // next state: the port granted this cycle, IDLE when nobody was
  always_comb begin
    state_nx = IDLE;
    if (p_gnt)      state_nx = OWN_P;
    else if (d_gnt) state_nx = OWN_D;
  end

  // grant decision: at most one grant per cycle, none while in reset
  always_comb begin
    p_gnt = 1'b0;
    d_gnt = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    // on contention the port that did not own last cycle wins; IDLE favours P
    d_wins = (state == OWN_P);
`else
    // D only beats P once it has been turned away MAX_WAIT cycles in a row
    d_wins = (wait_q >= MAX_WAIT_L);
`endif
    if (resetn) begin
      if (bus.p_req && bus.d_req) begin
        d_gnt = d_wins;
        p_gnt = !d_wins;
      end else begin
        p_gnt = bus.p_req;
        d_gnt = bus.d_req;
      end
    end
  end

`ifndef ARB_ROUND_ROBIN_EN
  // fixed priority never looks at the last owner
  logic unused_state;
  assign unused_state = ^state;
`endif

  // memory drive: granted port's access, else hold the last driven address/data
  always_comb begin
    addr_c  = addr_q;
    wdata_c = wdata_q;
    wren_c  = 1'b0;
    if (p_gnt) begin
      addr_c  = bus.p_addr;
      wdata_c = bus.p_wdata;
      wren_c  = bus.p_we;
    end else if (d_gnt) begin
      addr_c  = bus.d_addr;
      wdata_c = bus.d_wdata;
      wren_c  = bus.d_we;
    end
  end

  // registered copies of the last driven address/data for idle cycles
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (p_gnt || d_gnt) begin
      addr_q  <= addr_c;
      wdata_q <= wdata_c;
    end
  end

  // starvation counter: counts consecutive denied D cycles, saturates at 15
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)                   wait_q <= '0;
    else if (bus.d_req && !d_gnt)  wait_q <= (wait_q == 4'hF) ? wait_q : wait_q + 4'd1;
    else                           wait_q <= '0;
  end

  // read-in-flight flags; reset discards a pending read
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      p_pend <= 1'b0;
      d_pend <= 1'b0;
    end else begin
      p_pend <= p_gnt && !bus.p_we;
      d_pend <= d_gnt && !bus.d_we;
    end
  end

  // capture returned read data so each port's rdata holds until its next read
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      p_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      if (p_pend) p_rdata_q <= bus.mem_q;
      if (d_pend) d_rdata_q <= bus.mem_q;
    end
  end

  assign bus.p_gnt     = p_gnt;
  assign bus.d_gnt     = d_gnt;
  assign bus.mem_addr  = addr_c;
  assign bus.mem_wdata = wdata_c;
  assign bus.mem_wren  = wren_c;
  assign bus.p_rvalid  = p_pend;
  assign bus.d_rvalid  = d_pend;
  assign bus.p_rdata   = p_pend ? bus.mem_q : p_rdata_q;
  assign bus.d_rdata   = d_pend ? bus.mem_q : d_rdata_q;
  assign bus.d_wait    = wait_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: write-first RAM model, reference arbiter and per-port read scoreboards.
// Latency: checks grants/memory pins each cycle, read data one cycle after the model grants a read.
// Backpressure: random requesters hold their request until granted.
module tb_mem_port_arbiter;

  logic clock;
  logic resetn;
  int   total;
  int   bad;

  mem_port_arbiter_if bus ();

  mem_port_arbiter dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // write-first synchronous memory
  logic [15:0] ram [0:127];
  always @(posedge clock) begin
    if (bus.mem_wren) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_q <= bus.mem_wren ? bus.mem_wdata : ram[bus.mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model state
  logic [1:0]  m_state;
  logic [3:0]  m_dwait;
  logic        m_prv, m_drv;
  logic [6:0]  m_addr_q;
  logic [15:0] m_wdata_q;
  logic        e_pg, e_dg;
  logic [15:0] m_prdata, m_drdata;
  logic [15:0] shadow [0:127];
  logic [15:0] qp[$];
  logic [15:0] qd[$];

  // model registers, updated at the same edge as the DUT
  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      m_state   <= 2'd0;
      m_dwait   <= 4'd0;
      m_prv     <= 1'b0;
      m_drv     <= 1'b0;
      m_addr_q  <= 7'd0;
      m_wdata_q <= 16'd0;
    end else begin
      m_prv   <= e_pg && !bus.p_we;
      m_drv   <= e_dg && !bus.d_we;
      m_state <= e_pg ? 2'd1 : (e_dg ? 2'd2 : 2'd0);
      if (bus.d_req && !e_dg) m_dwait <= (m_dwait == 4'hF) ? m_dwait : m_dwait + 4'd1;
      else                    m_dwait <= 4'd0;
      if (e_pg) begin
        m_addr_q  <= bus.p_addr;
        m_wdata_q <= bus.p_wdata;
      end else if (e_dg) begin
        m_addr_q  <= bus.d_addr;
        m_wdata_q <= bus.d_wdata;
      end
    end
  end

  // shadow memory contents seen through the model's own grants
  always @(posedge clock) begin
    if (resetn) begin
      if (e_pg && bus.p_we)      shadow[bus.p_addr] <= bus.p_wdata;
      else if (e_dg && bus.d_we) shadow[bus.d_addr] <= bus.d_wdata;
    end
  end

  // per-cycle compare on the falling edge
  always @(negedge clock) begin : mon
    logic        epg, edg;
    logic [15:0] prd, drd;
    if (!resetn) begin
      epg = 1'b0;
      edg = 1'b0;
    end else if (bus.p_req && bus.d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
      edg = (m_state == 2'd1);
`else
      edg = (m_dwait >= 4'd4);
`endif
      epg = !edg;
    end else begin
      epg = bus.p_req;
      edg = bus.d_req;
    end
    chk("p_gnt", bus.p_gnt, epg);
    chk("d_gnt", bus.d_gnt, edg);
    chk("d_wait", bus.d_wait, m_dwait);
    chk("mem_wren", bus.mem_wren, epg ? bus.p_we : (edg ? bus.d_we : 1'b0));
    chk("mem_addr", bus.mem_addr, epg ? bus.p_addr : (edg ? bus.d_addr : m_addr_q));
    chk("mem_wdata", bus.mem_wdata, epg ? bus.p_wdata : (edg ? bus.d_wdata : m_wdata_q));
    prd = m_prdata;
    drd = m_drdata;
    if (!resetn) begin
      qp.delete();
      qd.delete();
      prd = 16'd0;
      drd = 16'd0;
    end else begin
      if (m_prv && qp.size() > 0) prd = qp.pop_front();
      if (m_drv && qd.size() > 0) drd = qd.pop_front();
    end
    chk("p_rvalid", bus.p_rvalid, m_prv);
    chk("d_rvalid", bus.d_rvalid, m_drv);
    chk("p_rdata", bus.p_rdata, prd);
    chk("d_rdata", bus.d_rdata, drd);
    m_prdata <= prd;
    m_drdata <= drd;
    if (epg && !bus.p_we) qp.push_back(shadow[bus.p_addr]);
    if (edg && !bus.d_we) qd.push_back(shadow[bus.d_addr]);
    e_pg <= epg;
    e_dg <= edg;
  end

  // drive one cycle of requests; returns just after the falling edge
  task automatic step(input logic pr, input logic pw, input logic [6:0] pa, input logic [15:0] pd,
                      input logic dr, input logic dw, input logic [6:0] da, input logic [15:0] dd);
    @(posedge clock);
    #1;
    bus.p_req = pr; bus.p_we = pw; bus.p_addr = pa; bus.p_wdata = pd;
    bus.d_req = dr; bus.d_we = dw; bus.d_addr = da; bus.d_wdata = dd;
    #5;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 7'd0, 16'd0, 1'b0, 1'b0, 7'd0, 16'd0);
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    resetn = 1'b0;
    bus.p_req = 1'b0; bus.p_we = 1'b0; bus.p_addr = '0; bus.p_wdata = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;

    // reset state, grant forced low with a request pending
    step(1'b1, 1'b0, 7'd5, 16'd0, 1'b1, 1'b0, 7'd9, 16'd0);
    chk("rst_pgnt", bus.p_gnt, 1'b0);
    chk("rst_dgnt", bus.d_gnt, 1'b0);
    chk("rst_dwait", bus.d_wait, 4'd0);
    idle();
    resetn = 1'b1;
    idle();

    // P only: write then read back
    step(1'b1, 1'b1, 7'd5, 16'h00AB, 1'b0, 1'b0, 7'd0, 16'd0);
    chk("pw_gnt", bus.p_gnt, 1'b1);
    chk("pw_wren", bus.mem_wren, 1'b1);
    step(1'b1, 1'b0, 7'd5, 16'd0, 1'b0, 1'b0, 7'd0, 16'd0);
    chk("pr_gnt", bus.p_gnt, 1'b1);
    chk("pr_wren", bus.mem_wren, 1'b0);
    idle();
    chk("pr_rvalid", bus.p_rvalid, 1'b1);
    chk("pr_rdata", bus.p_rdata, 16'h00AB);
    chk("pr_d_rvalid", bus.d_rvalid, 1'b0);
    idle();
    chk("pr_rvalid_once", bus.p_rvalid, 1'b0);
    chk("pr_rdata_hold", bus.p_rdata, 16'h00AB);

    // D only: read a location P filled
    step(1'b1, 1'b1, 7'h7F, 16'h1234, 1'b0, 1'b0, 7'd0, 16'd0);
    step(1'b0, 1'b0, 7'd0, 16'd0, 1'b1, 1'b0, 7'h7F, 16'd0);
    chk("dr_gnt", bus.d_gnt, 1'b1);
    chk("dr_pgnt", bus.p_gnt, 1'b0);
    idle();
    chk("dr_rvalid", bus.d_rvalid, 1'b1);
    chk("dr_rdata", bus.d_rdata, 16'h1234);
    chk("dr_p_rvalid", bus.p_rvalid, 1'b0);

    // reset in the middle of a P read
    step(1'b1, 1'b0, 7'd5, 16'd0, 1'b0, 1'b0, 7'd0, 16'd0);
    chk("mr_gnt", bus.p_gnt, 1'b1);
    resetn = 1'b0;
    #1;
    chk("mr_gnt_forced", bus.p_gnt, 1'b0);
    chk("mr_wren", bus.mem_wren, 1'b0);
    idle();
    chk("mr_rvalid", bus.p_rvalid, 1'b0);
    chk("mr_prdata", bus.p_rdata, 16'd0);
    chk("mr_drdata", bus.d_rdata, 16'd0);
    chk("mr_addr", bus.mem_addr, 7'd0);
    resetn = 1'b1;
    idle();
    chk("mr_no_rvalid", bus.p_rvalid, 1'b0);
    step(1'b1, 1'b0, 7'h7F, 16'd0, 1'b0, 1'b0, 7'd0, 16'd0);
    chk("mr_regrant", bus.p_gnt, 1'b1);
    idle();
    chk("mr_rdata", bus.p_rdata, 16'h1234);

    // contention: both held high from IDLE
    idle();
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 7'd5, 16'd0, 1'b1, 1'b0, 7'h7F, 16'd0);
`ifdef ARB_ROUND_ROBIN_EN
      chk("ct_dgnt", bus.d_gnt, (i % 2) == 1);
      chk("ct_pgnt", bus.p_gnt, (i % 2) == 0);
      chk("ct_dwait", bus.d_wait, i % 2);
`else
      chk("ct_dgnt", bus.d_gnt, (i % 5) == 4);
      chk("ct_pgnt", bus.p_gnt, (i % 5) != 4);
      chk("ct_dwait", bus.d_wait, i % 5);
`endif
    end
    idle();
    idle();

    // D write then P read of the same address on the next cycle
    step(1'b0, 1'b0, 7'd0, 16'd0, 1'b1, 1'b1, 7'd0, 16'hFFFF);
    chk("raw_dgnt", bus.d_gnt, 1'b1);
    chk("raw_wren", bus.mem_wren, 1'b1);
    step(1'b1, 1'b0, 7'd0, 16'd0, 1'b0, 1'b0, 7'd0, 16'd0);
    chk("raw_pgnt", bus.p_gnt, 1'b1);
    idle();
    chk("raw_rvalid", bus.p_rvalid, 1'b1);
    chk("raw_rdata", bus.p_rdata, 16'hFFFF);

    // D request withdrawn before it is ever granted
    step(1'b1, 1'b0, 7'd5, 16'd0, 1'b1, 1'b0, 7'd9, 16'd0);
    chk("drop_dgnt0", bus.d_gnt, 1'b0);
    step(1'b1, 1'b0, 7'd5, 16'd0, 1'b0, 1'b0, 7'd9, 16'd0);
    chk("drop_dgnt1", bus.d_gnt, 1'b0);
    chk("drop_dwait1", bus.d_wait, 4'd1);
    idle();
    chk("drop_dwait0", bus.d_wait, 4'd0);
    chk("drop_drvalid", bus.d_rvalid, 1'b0);

    // random traffic over a small address window
    for (int a = 0; a < 8; a++)
      step(1'b1, 1'b1, 7'(a), 16'(a * 3 + 1), 1'b0, 1'b0, 7'd0, 16'd0);
    for (int i = 0; i < 300; i++) begin
      logic pr, pw, dr, dw;
      logic [6:0]  pa, da;
      logic [15:0] pd, dd;
      if (bus.p_req && !bus.p_gnt) begin
        pr = 1'b1; pw = bus.p_we; pa = bus.p_addr; pd = bus.p_wdata;
      end else begin
        pr = ($urandom_range(0, 3) != 0); pw = 1'($urandom_range(0, 1));
        pa = 7'($urandom_range(0, 7));    pd = 16'($urandom);
      end
      if (bus.d_req && !bus.d_gnt) begin
        dr = 1'b1; dw = bus.d_we; da = bus.d_addr; dd = bus.d_wdata;
      end else begin
        dr = 1'($urandom_range(0, 1));    dw = 1'($urandom_range(0, 1));
        da = 7'($urandom_range(0, 7));    dd = 16'($urandom);
      end
      step(pr, pw, pa, pd, dr, dw, da, dd);
    end
    idle();
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
